// File: rtl/syscall_ctrl_pkg.sv
// Shared syscall codes and console constants for the syscall controller.
// The defines are guarded so other units can share the same syscall numbers.
`ifndef SYSCALL_DEFINES_SVH
`define SYSCALL_DEFINES_SVH
`define SYSCALL_PRINT_INT 32'd1
`define SYSCALL_EXIT      32'd10
`define SYSCALL_PUT_C     32'd11
`endif

package syscall_ctrl_pkg;
  localparam logic [31:0] SYSCALL_PRINT_INT = `SYSCALL_PRINT_INT;
  localparam logic [31:0] SYSCALL_EXIT      = `SYSCALL_EXIT;
  localparam logic [31:0] SYSCALL_PUT_C     = `SYSCALL_PUT_C;

  // 2^32-1 has ten decimal digits
  localparam int          DIGITS      = 10;
  localparam logic [7:0]  ASCII_MINUS = 8'h2D;
  localparam logic [7:0]  ASCII_NL    = 8'h0A;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction
endpackage

// File: rtl/syscall_ctrl_if.sv
// Execute-stage syscall request, stall/halt status and console byte handshake.
interface syscall_ctrl_if;
  logic        is_syscall;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param1;
  logic        stall;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        halted;

  modport master (
    output is_syscall, syscall_funct, syscall_param1, char_ready,
    input  stall, char_valid, char_data, halted
  );

  modport slave (
    input  is_syscall, syscall_funct, syscall_param1, char_ready,
    output stall, char_valid, char_data, halted
  );
endinterface

// File: rtl/syscall_ctrl_dec_digit.sv
// Combinational divide-by-ten step: one decimal digit per call.
module dec_digit (
  input  logic [31:0] value,
  output logic [31:0] quot,
  output logic [3:0]  rem
);
  assign quot = value / 32'd10;
  assign rem  = 4'(value % 32'd10);
endmodule

// File: rtl/syscall_ctrl.sv
// Syscall controller: stalls the pipeline while servicing put_c, print_int and exit,
// streaming console bytes over a valid/ready handshake.
module syscall_ctrl
  import syscall_ctrl_pkg::*;
#(
  parameter bit SIGNED_INT  = 1'b1,
  parameter bit INT_NEWLINE = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  syscall_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    EMIT    = 3'd2,
    DONE    = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [31:0]             val;
  logic [DIGITS-1:0][3:0]  stk;
  logic [3:0]              sp;
  logic                    neg;
  logic                    nl_pend;
  logic                    cv;
  logic [7:0]              cd;
  logic                    stall;

  logic [31:0] quot;
  logic [3:0]  rem;
  logic        xfer;
  logic        neg_in;
  logic [31:0] mag_in;

  dec_digit u_dec (.value(val), .quot(quot), .rem(rem));

  assign xfer   = cv && bus.char_ready;
  assign neg_in = SIGNED_INT && bus.syscall_param1[31];
  // two's-complement negation as unsigned keeps 32'h80000000 correct
  assign mag_in = neg_in ? (~bus.syscall_param1 + 32'd1) : bus.syscall_param1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (bus.is_syscall) begin
        stall = 1'b1;
        case (bus.syscall_funct)
          SYSCALL_PUT_C:     state_nxt = EMIT;
          SYSCALL_PRINT_INT: state_nxt = CONVERT;
          SYSCALL_EXIT:      state_nxt = HALT;
          default:           state_nxt = DONE;
        endcase
      end
      CONVERT: begin
        stall = 1'b1;
        if (quot == 32'd0) state_nxt = EMIT;
      end
      EMIT: begin
        stall = 1'b1;
        if (xfer && sp == 4'd0 && !nl_pend) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      HALT:    stall = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // The next byte is loaded on the edge that completes the previous transfer,
  // so char_valid is a flop and never a function of char_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val     <= '0;
      stk     <= '0;
      sp      <= '0;
      neg     <= 1'b0;
      nl_pend <= 1'b0;
      cv      <= 1'b0;
      cd      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.is_syscall) begin
          val     <= mag_in;
          neg     <= neg_in;
          sp      <= '0;
          nl_pend <= 1'b0;
          if (bus.syscall_funct == SYSCALL_PUT_C) begin
            cv <= 1'b1;
            cd <= bus.syscall_param1[7:0];
          end
        end
        CONVERT: begin
          val <= quot;
          if (quot == 32'd0) begin
            cv      <= 1'b1;
            nl_pend <= INT_NEWLINE;
            // the MS digit goes straight to the output unless '-' precedes it
            if (neg) begin
              stk[sp] <= rem;
              sp      <= sp + 4'd1;
              cd      <= ASCII_MINUS;
            end else begin
              cd      <= ascii_digit(rem);
            end
          end else begin
            stk[sp] <= rem;
            sp      <= sp + 4'd1;
          end
        end
        EMIT: if (xfer) begin
          if (sp != 4'd0) begin
            cd <= ascii_digit(stk[sp - 4'd1]);
            sp <= sp - 4'd1;
          end else if (nl_pend) begin
            cd      <= ASCII_NL;
            nl_pend <= 1'b0;
          end else begin
            cv <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall      = stall;
  assign bus.char_valid = cv;
  assign bus.char_data  = cd;
  assign bus.halted     = (state == HALT);
endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl: console byte streams, stall timing, exit and reset.
module tb_syscall_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;

  syscall_ctrl_if bus ();

  syscall_ctrl #(.SIGNED_INT(1'b1), .INT_NEWLINE(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] bq[$];
  bit         pat_en = 1'b0;
  logic [3:0] pat    = 4'b1001;
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // console side: ready always high, or cycling 1,0,0,1
  initial begin
    bus.char_ready = 1'b1;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clock);
        #1;
        bus.char_ready = pat_en ? pat[i] : 1'b1;
      end
    end
  end

  // byte collector plus hold-stability check while the console back-pressures
  always @(negedge clock) begin
    if (reset) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, bus.char_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.char_data}, {24'd0, data_prev});
      end
      if (bus.char_valid && bus.char_ready) bq.push_back(bus.char_data);
      hold_prev <= bus.char_valid && !bus.char_ready;
      data_prev <= bus.char_data;
    end
  end

  task automatic do_sys(input logic [31:0] f, input logic [31:0] p, output int sc);
    bit done;
    done = 1'b0;
    sc   = 0;
    @(posedge clock);
    #1;
    bus.is_syscall     = 1'b1;
    bus.syscall_funct  = f;
    bus.syscall_param1 = p;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      if (bus.stall) sc++;
      else           done = 1'b1;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    chk("done_no_valid", {31'd0, bus.char_valid}, 32'd0);
    @(posedge clock);
    #1;
    bus.is_syscall = 1'b0;
    @(negedge clock);
    chk("idle_stall", {31'd0, bus.stall}, 32'd0);
    chk("idle_valid", {31'd0, bus.char_valid}, 32'd0);
  endtask

  task automatic expect_str(input string tag, input string s);
    chk({tag, "_len"}, bq.size(), s.len());
    for (int i = 0; i < s.len() && i < bq.size(); i++)
      chk(tag, {24'd0, bq[i]}, {24'd0, s[i]});
    bq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    bus.is_syscall     = 1'b0;
    bus.syscall_funct  = '0;
    bus.syscall_param1 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_valid", {31'd0, bus.char_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.char_data}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    do_sys(32'd11, 32'h141, sc);
    chk("putc_stall", sc, 32'd2);
    expect_str("putc", "A");

    do_sys(32'd7, 32'd99, sc);
    chk("unk_stall", sc, 32'd1);
    expect_str("unk", "");

    do_sys(32'd1, 32'hFFFF_FECF, sc);
    chk("n305_stall", sc, 32'd9);
    expect_str("n305", "-305\n");

    do_sys(32'd1, 32'd0, sc);
    chk("zero_stall", sc, 32'd4);
    expect_str("zero", "0\n");

    do_sys(32'd1, 32'h8000_0000, sc);
    chk("min_stall", sc, 32'd23);
    expect_str("min", "-2147483648\n");

    pat_en = 1'b1;
    do_sys(32'd1, 32'd42, sc);
    pat_en = 1'b0;
    expect_str("bp42", "42\n");

    // exit: halt is sticky until reset
    @(posedge clock);
    #1;
    bus.is_syscall    = 1'b1;
    bus.syscall_funct = 32'd10;
    @(negedge clock);
    chk("exit_acc_stall", {31'd0, bus.stall}, 32'd1);
    chk("exit_acc_halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clock);
    chk("exit_halted", {31'd0, bus.halted}, 32'd1);
    chk("exit_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clock);
    #1;
    bus.is_syscall = 1'b0;
    repeat (3) @(negedge clock);
    chk("halt_stall_idle", {31'd0, bus.stall}, 32'd1);
    @(posedge clock);
    #1;
    bus.is_syscall     = 1'b1;
    bus.syscall_funct  = 32'd11;
    bus.syscall_param1 = 32'h5A;
    repeat (4) @(negedge clock);
    chk("halt_still", {31'd0, bus.halted}, 32'd1);
    chk("halt_no_valid", {31'd0, bus.char_valid}, 32'd0);
    chk("halt_no_bytes", bq.size(), 32'd0);
    @(posedge clock);
    #1;
    bus.is_syscall = 1'b0;
    reset = 1'b1;
    #1;
    chk("halt_rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("halt_rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // reset in the middle of converting 123456
    @(posedge clock);
    #1;
    bus.is_syscall     = 1'b1;
    bus.syscall_funct  = 32'd1;
    bus.syscall_param1 = 32'd123456;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("conv_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b1;
    bus.is_syscall = 1'b0;
    #1;
    chk("rconv_valid", {31'd0, bus.char_valid}, 32'd0);
    chk("rconv_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bq.delete();
    do_sys(32'd11, 32'h5A, sc);
    chk("after_rst_stall", sc, 32'd2);
    expect_str("after_rst", "Z");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/syscall_ctrl.md
SYSCALL_CTRL -- requirements
Module: syscall_ctrl

Interface
REQ-001 Parameter SIGNED_INT, default 1: print_int prints syscall_param1 as two's-complement signed (1) or unsigned (0).
REQ-002 Parameter INT_NEWLINE, default 1: print_int appends 8'h0A after the last digit.
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port is_syscall, input, 1: execute stage holds a syscall instruction.
REQ-006 Port syscall_funct, input, 32: syscall code ($v0).
REQ-007 Port syscall_param1, input, 32: first argument ($a0).
REQ-008 Port stall, output, 1: freezes execute and all earlier stages.
REQ-009 Port char_valid, output, 1: char_data holds a console byte.
REQ-010 Port char_data, output, 8: console byte.
REQ-011 Port char_ready, input, 1: console accepts the byte this cycle.
REQ-012 Port halted, output, 1: program has executed exit.

Function
REQ-013 States: IDLE, CONVERT, EMIT, DONE, HALT.
REQ-014 IDLE with is_syscall=1 is acceptance: funct and param1 captured, stall=1 combinationally in that cycle.
REQ-015 stall=1 in CONVERT, EMIT and HALT; stall=0 in IDLE without is_syscall and in DONE.
REQ-016 DONE lasts exactly one cycle, ignores is_syscall, then goes to IDLE; the syscall leaves execute here.
REQ-017 SYSCALL_PUT_C: IDLE->EMIT, one byte = param1[7:0], first char_valid in the cycle after acceptance.
REQ-018 SYSCALL_PRINT_INT: IDLE->CONVERT; one decimal digit per cycle (value/10, value%10) pushed LS-first into a 10-entry digit stack until quotient is 0; minimum one digit.
REQ-019 Signed negative value: magnitude = two's-complement negation as unsigned 32-bit; 32'h80000000 yields "-2147483648"; leading '-' (8'h2D) emitted first.
REQ-020 EMIT order for print_int: optional '-', digits MS-first as 8'h30+d, then optional 8'h0A; no leading zeros.
REQ-021 SYSCALL_EXIT: IDLE->HALT; halted=1 from the next cycle; stall=1 forever; leaves HALT only via reset.
REQ-022 Unknown funct: IDLE->DONE; no bytes emitted.
REQ-023 Handshake: byte transfers when char_valid&&char_ready; char_valid and char_data stable until transfer; char_valid never depends combinationally on char_ready.
REQ-024 Back-to-back bytes: a next byte is presented in the cycle after a transfer, giving one byte per cycle with char_ready held high.
REQ-025 After the last byte transfers, EMIT->DONE.
REQ-026 char_ready ignored when char_valid=0.

Reset
REQ-027 Reset asserted in any state, mid-conversion or mid-handshake included, forces IDLE within the same cycle.
REQ-028 Reset values: stall=0, char_valid=0, char_data=8'h00, halted=0, digit stack pointer=0; partially emitted output is abandoned.

Structure
REQ-029 SYSCALL_PRINT_INT (1), SYSCALL_EXIT (10) and SYSCALL_PUT_C (11) SHALL live in the shared syscall defines header, guarded by `ifndef.
REQ-030 State encodings SHALL be local constants of syscall_ctrl.
REQ-031 One combinational sub-module, dec_digit, SHALL compute quotient/10 and remainder%10 of a 32-bit unsigned value.

Verification
REQ-032 put_c param1=32'h141, char_ready=1 -> one byte 8'h41, stall high 2 cycles, then DONE one cycle.
REQ-033 print_int param1=-305 -> bytes 2D,33,30,35,0A; stall released only in DONE.
REQ-034 print_int param1=0 -> bytes 30,0A; print_int 32'h80000000 -> "-2147483648\n".
REQ-035 print_int 42 with char_ready toggling 1,0,0,1 -> char_data stable while stalled by char_ready; bytes 34,32,0A, none lost or duplicated.
REQ-036 exit -> halted=1 next cycle, stall stuck at 1, later is_syscall ignored; reset -> halted=0, stall=0.
REQ-037 Reset asserted during CONVERT of 123456 -> char_valid=0 immediately; a following put_c 8'h5A emits only 5A.
